// File: rtl/vpu_req_arbiter_if.sv
// Request/command bus between the requesters, the arbiter and the VPU port.
// The slave modport is the arbiter's view; master is the surrounding
// system (requesters plus VPU) that drives the inputs and observes the pulses.
interface vpu_req_arbiter_if #(
    parameter int REQ_CNT   = 4,
    parameter int CMD_WIDTH = 64
);
    logic [REQ_CNT-1:0]           req_valid_i;
    logic [REQ_CNT*CMD_WIDTH-1:0] req_cmd_i;
    logic [REQ_CNT-1:0]           req_ready_o;
    logic [REQ_CNT-1:0]           req_done_o;
    logic [REQ_CNT-1:0]           req_err_o;
    logic                         vpu_valid_o;
    logic [CMD_WIDTH-1:0]         vpu_cmd_o;
    logic                         vpu_ready_i;
    logic                         vpu_done_i;

    modport slave (
        input  req_valid_i, req_cmd_i, vpu_ready_i, vpu_done_i,
        output req_ready_o, req_done_o, req_err_o, vpu_valid_o, vpu_cmd_o
    );

    modport master (
        output req_valid_i, req_cmd_i, vpu_ready_i, vpu_done_i,
        input  req_ready_o, req_done_o, req_err_o, vpu_valid_o, vpu_cmd_o
    );
endinterface

// File: rtl/vpu_req_arbiter.sv
// Round-robin arbiter sharing the single VPU request channel. One command is
// in flight at a time; completion or a watchdog timeout is returned as a
// one-cycle pulse to the requester that issued it.
module vpu_req_arbiter #(
    parameter int  REQ_CNT        = 4,
    parameter int  CMD_WIDTH      = 64,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int IDW            = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    vpu_req_arbiter_if.slave   bus,
    output logic               busy_o,
    output logic [IDW-1:0]     grant_id_o
);

    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW > 0) ? TW_RAW : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LAST =
        WDOG_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDW-1:0] ID_MAX = IDW'(REQ_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       id_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [TW-1:0]        timer_q;
    logic [REQ_CNT-1:0]   done_q;
    logic [REQ_CNT-1:0]   err_q;

    logic [IDW-1:0]       grant;
    logic                 grant_vld;
    logic [CMD_WIDTH-1:0] grant_cmd;
    logic [REQ_CNT-1:0]   ready_d;
    logic                 vpu_valid_d;
    logic                 timeout_hit;
    logic [REQ_CNT-1:0]   id_onehot;
    logic [IDW-1:0]       rr_next;
    logic [IDW:0]         scan_idx;

    // Round-robin scan: first pending requester starting at rr_ptr, with wrap;
    // also selects the granted requester's command slice.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_cmd = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < REQ_CNT; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (scan_idx >= (IDW+1)'(REQ_CNT)) begin
                scan_idx = scan_idx - (IDW+1)'(REQ_CNT);
            end
            if (!grant_vld && bus.req_valid_i[scan_idx[IDW-1:0]]) begin
                grant     = scan_idx[IDW-1:0];
                grant_vld = 1'b1;
            end
        end
        for (int unsigned k = 0; k < REQ_CNT; k++) begin
            if (grant == IDW'(k)) begin
                grant_cmd = bus.req_cmd_i[k*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        ready_d     = '0;
        vpu_valid_d = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    ready_d[grant] = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                vpu_valid_d = 1'b1;
                if (bus.vpu_ready_i) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                timeout_hit = WDOG_EN && (timer_q == TIMER_LAST);
                if (bus.vpu_done_i || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Helpers for the completion path: pulse target and pointer advance.
    always_comb begin
        id_onehot = REQ_CNT'(1) << id_q;
        rr_next   = (id_q == ID_MAX) ? '0 : id_q + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, pointer, watchdog timer and completion pulse flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            cmd_q    <= '0;
            timer_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        cmd_q <= grant_cmd;
                        id_q  <= grant;
                    end
                end
                S_ISSUE: begin
                    if (bus.vpu_ready_i) begin
                        timer_q <= '0;
                    end
                end
                S_BUSY: begin
                    if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                    // Done takes priority over a timeout landing in the same cycle.
                    if (bus.vpu_done_i) begin
                        done_q   <= id_onehot;
                        rr_ptr_q <= rr_next;
                    end else if (timeout_hit) begin
                        err_q    <= id_onehot;
                        rr_ptr_q <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = ready_d;
    assign bus.req_done_o  = done_q;
    assign bus.req_err_o   = err_q;
    assign bus.vpu_valid_o = vpu_valid_d;
    assign bus.vpu_cmd_o   = cmd_q;
    assign busy_o          = (state_q != S_IDLE);
    assign grant_id_o      = id_q;

endmodule

// File: doc/vpu_req_arbiter.md
# vpu_req_arbiter

Round-robin arbiter that shares one VPU request channel among REQ_CNT requesters (DMA engines, host command queue, NPU sequencer) and sits directly in front of the VPU top-level request port. It accepts one command at a time, drives it to the VPU with a valid/ready handshake, and waits for VPU completion before granting again. Completion, or a watchdog timeout, is returned as a one-cycle pulse to the requester that issued the command.

## Interface
Parameters:
- REQ_CNT, 4, number of requesters (1..16)
- CMD_WIDTH, 64, packed VPU command word width
- TIMEOUT_CYCLES, 1024, BUSY-cycle watchdog limit; 0 disables the watchdog
- IDW, $clog2(REQ_CNT) (minimum 1), grant id width (derived)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  REQ_CNT  requester k has a command pending
- req_cmd_i  in  REQ_CNT*CMD_WIDTH  requester k command at [k*CMD_WIDTH +: CMD_WIDTH]
- req_ready_o  out  REQ_CNT  one-hot accept pulse; command taken this cycle
- req_done_o  out  REQ_CNT  one-hot completion pulse
- req_err_o  out  REQ_CNT  one-hot timeout pulse
- vpu_valid_o  out  1  command valid toward VPU
- vpu_cmd_o  out  CMD_WIDTH  latched command
- vpu_ready_i  in  1  VPU accepts command
- vpu_done_i  in  1  VPU operation complete (single-cycle pulse)
- busy_o  out  1  state != IDLE
- grant_id_o  out  IDW  index of current/last granted requester

## Operation
- States: IDLE, ISSUE, BUSY. Registers: state, rr_ptr (IDW bits), cmd_q, id_q, timer, done/err pulse flops.
- IDLE: if any req_valid_i bit is set, grant g = the first set index scanning rr_ptr, rr_ptr+1, … with modulo-REQ_CNT wrap.
  - req_ready_o[g] = 1 combinationally in the same cycle.
  - cmd_q <= req_cmd_i slice g; id_q <= g; next state ISSUE.
  - With no request, stay in IDLE.
- ISSUE: vpu_valid_o = 1 and vpu_cmd_o = cmd_q, held stable until vpu_ready_i = 1. Then next state BUSY, timer <= 0.
- BUSY: timer increments by 1 each cycle.
  - On vpu_done_i: req_done_o[id_q] pulses the next cycle; state <= IDLE; rr_ptr <= (id_q+1) mod REQ_CNT.
  - Else, if TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1: req_err_o[id_q] pulses the next cycle; state <= IDLE; rr_ptr advances as for done.
  - If vpu_done_i and timeout occur in the same cycle, done wins; no err pulse.
- vpu_ready_i outside ISSUE and vpu_done_i outside BUSY are ignored. No pulse, no state change.
- req_valid_i is sampled only in IDLE. A requester deasserting valid after its grant has no effect. The requester must present a new command on the cycle after its ready pulse if it has one.
- grant_id_o = id_q (registered).
- Timer width: $clog2(TIMEOUT_CYCLES+1), saturating. It never wraps.
- At most one bit of req_ready_o, req_done_o and req_err_o is set in any cycle.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, rr_ptr 0, id_q 0, cmd_q 0, timer 0. All outputs 0: req_ready_o, req_done_o, req_err_o, vpu_valid_o, vpu_cmd_o, busy_o, grant_id_o.
- Reset mid-ISSUE or mid-BUSY drops vpu_valid_o immediately. No done or err pulse is emitted for the aborted command.
- Request at cycle t in IDLE: req_ready_o at t, vpu_valid_o at t+1. If vpu_ready_i is high at t+1, busy in BUSY from t+2.
- vpu_done_i at cycle d: req_done_o at d+1. State is IDLE at d+1, so a new grant's req_ready_o can also occur at d+1.
- Minimum issue-to-issue spacing: 3 cycles (IDLE, ISSUE, BUSY with immediate done).
- Timeout: BUSY entered at cycle b, no done: err pulse at b+TIMEOUT_CYCLES.

## Test plan
- Single requester, REQ_CNT=4: req_valid_i=4'b0100, cmd 0xA5 at t0 -> req_ready_o=4'b0100 at t0; vpu_valid_o with vpu_cmd_o=0xA5 at t0+1; done at t0+5 -> req_done_o=4'b0100 at t0+6; grant_id_o=2.
- Fairness: all four valid continuously, VPU ready and done immediately -> grant order 0,1,2,3,0,1. No requester is granted twice before all others.
- Backpressure: vpu_ready_i low 5 cycles in ISSUE, while req_cmd_i is changed -> vpu_valid_o stays 1, vpu_cmd_o constant, no second req_ready_o.
- Watchdog, TIMEOUT_CYCLES=16: no vpu_done_i -> req_err_o[id] at BUSY entry +16, no req_done_o, rr_ptr advanced. Separately, done and timeout in the same cycle -> req_done_o only.
- Spurious inputs: vpu_done_i pulse in IDLE and vpu_ready_i in BUSY -> no outputs change.
- Reset in BUSY: rst_n low for 1 cycle -> all outputs 0 immediately. After release, the next grant starts from requester 0.
